// File: rtl/axi4lite_write_slave_if.sv
// ---------------------------------------------------------------------------
// axi4lite_write_slave_if
//
// AXI4-Lite write-channel bundle (AW, W, B) between an interconnect master and
// the axi4lite_write_slave.
//
// Parameters:
//   ADDR_WIDTH - width of s_awaddr
//   DATA_WIDTH - width of s_wdata (32 or 64)
//
// Signals:
//   s_awaddr, s_awvalid, s_awready   write address channel
//   s_wdata, s_wstrb, s_wvalid, s_wready
//                                    write data channel (s_wstrb only when
//                                    AXI4LITE_WR_WSTRB_EN is defined)
//   s_bresp, s_bvalid, s_bready      write response channel
//
// Modports: master (drives AW/W, consumes B), slave (the opposite).
// ---------------------------------------------------------------------------
interface axi4lite_write_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
`ifdef AXI4LITE_WR_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] s_wstrb;
`endif
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;

    modport master (
`ifdef AXI4LITE_WR_WSTRB_EN
        output s_wstrb,
`endif
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        input  s_awready, s_wready, s_bresp, s_bvalid
    );

    modport slave (
`ifdef AXI4LITE_WR_WSTRB_EN
        input  s_wstrb,
`endif
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        output s_awready, s_wready, s_bresp, s_bvalid
    );
endinterface

// File: rtl/axi4lite_write_slave.sv
// ---------------------------------------------------------------------------
// axi4lite_write_slave
//
// AXI4-Lite write-channel slave. Accepts the AW and W beats in either order
// (or together), decodes the captured address against a window of NUM_REGS
// registers, issues a one-cycle write pulse to the local register block and
// returns OKAY or SLVERR on the B channel. One write is in flight at a time.
//
// Optional feature macro: AXI4LITE_WR_WSTRB_EN
//   defined   - s_wstrb is used; wr_strb follows it and an all-zero strobe
//               suppresses wr_en while still answering OKAY.
//   undefined - no s_wstrb; every legal write is a full-word write.
//
// Parameters:
//   ADDR_WIDTH - address width
//   DATA_WIDTH - data width, 32 or 64
//   NUM_REGS   - registers in the window, power of two, >= 2
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   s        slave modport of axi4lite_write_slave_if (AW/W/B channels)
//   wr_en    out  one-cycle register write pulse
//   wr_idx   out  register index
//   wr_data  out  write data
//   wr_strb  out  byte enables
// ---------------------------------------------------------------------------
module axi4lite_write_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    axi4lite_write_slave_if.slave       s,
    output logic                        wr_en,
    output logic [$clog2(NUM_REGS)-1:0] wr_idx,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [DATA_WIDTH/8-1:0]     wr_strb
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HAVE_A = 3'd1,
        HAVE_W = 3'd2,
        COMMIT = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [BYTES-1:0]       strb_q;
    logic [1:0]             bresp_q;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   addr_err;
    logic                   strb_any;

    // Readies and bvalid decode purely from the state register, so there is
    // no path from a valid input to a ready output. Reset is folded in so the
    // channel is closed for the whole time reset is high and opens in the
    // very first cycle after it drops.
    assign s.s_awready = ~reset & ((state_q == IDLE) | (state_q == HAVE_W));
    assign s.s_wready  = ~reset & ((state_q == IDLE) | (state_q == HAVE_A));
    assign s.s_bvalid  = ~reset & (state_q == RESP);
    assign s.s_bresp   = bresp_q;

    assign aw_hs = s.s_awvalid & s.s_awready;
    assign w_hs  = s.s_wvalid  & s.s_wready;

    // Out of range when any bit above the index field is set; misaligned when
    // any byte-offset bit is set.
    assign addr_err = (|(addr_q >> (LSB + IDX_W))) | (|addr_q[LSB-1:0]);

`ifdef AXI4LITE_WR_WSTRB_EN
    assign strb_any = |strb_q;
`else
    assign strb_any = 1'b1;
`endif

    assign wr_en   = ~reset & (state_q == COMMIT) & ~addr_err & strb_any;
    assign wr_idx  = addr_q[LSB +: IDX_W];
    assign wr_data = data_q;
    assign wr_strb = strb_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = COMMIT;
                end else if (aw_hs) begin
                    state_d = HAVE_A;
                end else if (w_hs) begin
                    state_d = HAVE_W;
                end
            end
            HAVE_A: begin
                if (w_hs) begin
                    state_d = COMMIT;
                end
            end
            HAVE_W: begin
                if (aw_hs) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = RESP;
            end
            RESP: begin
                if (s.s_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                addr_q <= s.s_awaddr;
            end
            if (w_hs) begin
                data_q <= s.s_wdata;
`ifdef AXI4LITE_WR_WSTRB_EN
                strb_q <= s.s_wstrb;
`else
                strb_q <= '1;
`endif
            end
            // Response is fixed in the commit cycle and held through RESP.
            if (state_q == COMMIT) begin
                bresp_q <= addr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_write_slave.sv
module tb_axi4lite_write_slave;
    localparam int NUM_REGS = 16;
    localparam int BYTES    = 4;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    int checks = 0;
    int errors = 0;

    axi4lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4lite_write_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (NUM_REGS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s      (bus.slave),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_data(wr_data),
        .wr_strb(wr_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file image built from accepted writes (byte-granular).
    logic [31:0] regfile [NUM_REGS];

    // One complete write transaction. Called at a negedge, returns at the
    // negedge where the slave should be idle again. The expected outcome is
    // computed from the address/strobe rules, not from the slave's state.
    task automatic do_write(input string name, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input bit probe);
        bit          aw_done = 0;
        bit          w_done  = 0;
        bit          aw_rdy, w_rdy;
        int          c = 0;
        bit          exp_err;
        bit          exp_en;
        logic [3:0]  exp_idx;
        logic [3:0]  exp_strb;
        logic [1:0]  exp_bresp;
        logic [31:0] got_data;

        exp_err = (addr >= 32'(NUM_REGS * BYTES)) || ((addr % BYTES) != 0);
`ifdef AXI4LITE_WR_WSTRB_EN
        exp_strb = strb;
`else
        exp_strb = 4'hF;
`endif
        exp_en    = !exp_err && (exp_strb != 4'h0);
        exp_idx   = 4'((addr / BYTES) % NUM_REGS);
        exp_bresp = exp_err ? 2'b10 : 2'b00;

        // Collect both beats.
        while (!(aw_done && w_done)) begin
            checks++;
            if ({bus.s_awready, bus.s_wready, wr_en, bus.s_bvalid} !== {!aw_done, !w_done, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s collect: {awready,wready,wr_en,bvalid}=%b expected %b", name,
                         {bus.s_awready, bus.s_wready, wr_en, bus.s_bvalid}, {!aw_done, !w_done, 2'b00});
            end
            aw_rdy        = bus.s_awready;
            w_rdy         = bus.s_wready;
            bus.s_awvalid = !aw_done && (c >= aw_dly);
            bus.s_awaddr  = addr;
            bus.s_wvalid  = !w_done && (c >= w_dly);
            bus.s_wdata   = data;
`ifdef AXI4LITE_WR_WSTRB_EN
            bus.s_wstrb   = strb;
`endif
            @(posedge clk);
            if (bus.s_awvalid && aw_rdy) aw_done = 1;
            if (bus.s_wvalid && w_rdy)   w_done  = 1;
            @(negedge clk);
            c++;
            if (c > 40) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: beats not accepted aw=%0b w=%0b expected both", name, aw_done, w_done);
                bus.s_awvalid = 0;
                bus.s_wvalid  = 0;
                return;
            end
        end
        bus.s_awvalid = 0;
        bus.s_wvalid  = 0;
        bus.s_bready  = (b_dly == 0);

        // Commit cycle (N+1).
        checks++;
        if ({wr_en, bus.s_awready, bus.s_wready, bus.s_bvalid} !== {exp_en, 3'b000}) begin
            errors++;
            $display("FAIL %s commit: {wr_en,awready,wready,bvalid}=%b expected %b", name,
                     {wr_en, bus.s_awready, bus.s_wready, bus.s_bvalid}, {exp_en, 3'b000});
        end
        if (exp_en) begin
            checks++;
            if ({wr_idx, wr_data, wr_strb} !== {exp_idx, data, exp_strb}) begin
                errors++;
                $display("FAIL %s wr_port: idx=%0d data=%h strb=%b expected idx=%0d data=%h strb=%b",
                         name, wr_idx, wr_data, wr_strb, exp_idx, data, exp_strb);
            end
            for (int b = 0; b < BYTES; b++)
                if (exp_strb[b]) regfile[exp_idx][8*b +: 8] = data[8*b +: 8];
        end

        // Response cycles (N+2 onward), held for b_dly cycles of backpressure.
        @(negedge clk);
        for (int i = 0; i <= b_dly; i++) begin
            checks++;
            if ({bus.s_bvalid, bus.s_bresp, wr_en, bus.s_awready, bus.s_wready} !== {1'b1, exp_bresp, 3'b000}) begin
                errors++;
                $display("FAIL %s resp[%0d]: {bvalid,bresp,wr_en,awready,wready}=%b expected %b", name, i,
                         {bus.s_bvalid, bus.s_bresp, wr_en, bus.s_awready, bus.s_wready}, {1'b1, exp_bresp, 3'b000});
            end
            if (i < b_dly) begin
                if (probe) begin
                    bus.s_awvalid = 1;
                    bus.s_awaddr  = $urandom;
                    bus.s_wvalid  = 1;
                    bus.s_wdata   = $urandom;
                end
                @(negedge clk);
            end
        end
        bus.s_awvalid = 0;
        bus.s_wvalid  = 0;
        bus.s_bready  = 1;
        @(negedge clk);
        bus.s_bready  = 0;
        checks++;
        if ({bus.s_bvalid, bus.s_awready, bus.s_wready, wr_en} !== 4'b0110) begin
            errors++;
            $display("FAIL %s done: {bvalid,awready,wready,wr_en}=%b expected 0110", name,
                     {bus.s_bvalid, bus.s_awready, bus.s_wready, wr_en});
        end
        got_data = regfile[exp_idx];
        $display("txn %s addr=%h data=%h strb=%b aw_dly=%0d w_dly=%0d b_dly=%0d bresp=%b wr=%0b reg[%0d]=%h",
                 name, addr, data, exp_strb, aw_dly, w_dly, b_dly, exp_bresp, exp_en, exp_idx, got_data);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.s_awready, bus.s_wready, wr_en, bus.s_bvalid, bus.s_bresp} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {awready,wready,wr_en,bvalid,bresp}=%b expected 000000",
                     {bus.s_awready, bus.s_wready, wr_en, bus.s_bvalid, bus.s_bresp});
        end
        checks++;
        if ({wr_idx, wr_data, wr_strb} !== 40'b0) begin
            errors++;
            $display("FAIL reset_data: idx=%0d data=%h strb=%b expected 0", wr_idx, wr_data, wr_strb);
        end
        reset = 0;
        #1;
        checks++;
        if ({bus.s_awready, bus.s_wready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: {awready,wready}=%b expected 11", {bus.s_awready, bus.s_wready});
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        do_write("simul", 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    endtask

    task automatic test_w_before_aw();
        do_write("w_first", 32'h3C, 32'h12345678, 4'hF, 4, 0, 0, 0);
        do_write("a_first", 32'h14, 32'hCAFEF00D, 4'hF, 0, 3, 1, 0);
    endtask

    task automatic test_addr_errors();
        do_write("oor", 32'h40, 32'h11111111, 4'hF, 0, 0, 0, 0);
        do_write("misalign", 32'h06, 32'h22222222, 4'hF, 1, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        do_write("bp", 32'h20, 32'hA5A55A5A, 4'hF, 0, 0, 5, 1);
    endtask

    task automatic test_mid_reset();
        bus.s_awvalid = 1;
        bus.s_awaddr  = 32'h10;
        @(negedge clk);
        bus.s_awvalid = 0;
        checks++;
        if ({bus.s_awready, bus.s_wready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset_have_a: {awready,wready}=%b expected 01", {bus.s_awready, bus.s_wready});
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({bus.s_awready, bus.s_wready, wr_en, bus.s_bvalid, bus.s_bresp} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: {awready,wready,wr_en,bvalid,bresp}=%b expected 000000",
                     {bus.s_awready, bus.s_wready, wr_en, bus.s_bvalid, bus.s_bresp});
        end
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if ({bus.s_awready, bus.s_wready, bus.s_bvalid, wr_en} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_reset_idle: {awready,wready,bvalid,wr_en}=%b expected 1100",
                     {bus.s_awready, bus.s_wready, bus.s_bvalid, wr_en});
        end
        // A lone W must not complete against the discarded address.
        do_write("post_rst", 32'h30, 32'h0BADC0DE, 4'hF, 3, 0, 0, 0);
    endtask

`ifdef AXI4LITE_WR_WSTRB_EN
    task automatic test_strobes();
        do_write("strb5", 32'h04, 32'h89ABCDEF, 4'b0101, 0, 0, 0, 0);
        do_write("strb0", 32'h04, 32'h01020304, 4'b0000, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_write("b2b", 32'(i * 4), $urandom, 4'hF, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = 32'($urandom_range(0, NUM_REGS - 1) * BYTES);
                2:       addr = 32'($urandom_range(0, NUM_REGS - 1) * BYTES + $urandom_range(1, BYTES - 1));
                default: addr = 32'h40 + $urandom_range(0, 1000);
            endcase
            do_write("rand", addr, $urandom, 4'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regfile[i] = '0;
        reset         = 1;
        bus.s_awvalid = 0;
        bus.s_awaddr  = '0;
        bus.s_wvalid  = 0;
        bus.s_wdata   = '0;
`ifdef AXI4LITE_WR_WSTRB_EN
        bus.s_wstrb   = '0;
`endif
        bus.s_bready  = 0;
        @(negedge clk);
        test_reset();
        test_simultaneous();
        test_w_before_aw();
        test_addr_errors();
        test_backpressure();
        test_mid_reset();
`ifdef AXI4LITE_WR_WSTRB_EN
        test_strobes();
`endif
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
